// File: rtl/dsp48a1_mac_seq.sv
// Sequencer in front of a DSP48A1 slice: streams operand pairs plus OPMODE tags so the
// slice accumulates one signed dot product per vector, then holds the final P as a result.
module dsp48a1_mac_seq #(
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [47:0]      res_data,
  output logic [CNT_W-1:0] res_count,
  output logic             res_trunc,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  output logic             dsp_rst,
  input  logic [47:0]      dsp_p,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the source holds
  // its payload stable until then, and ready never depends combinationally on valid.

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  localparam logic [7:0] OP_CLEAR = 8'h00;  // P <= 0
  localparam logic [7:0] OP_MUL   = 8'h01;  // P <= M
  localparam logic [7:0] OP_MAC   = 8'h09;  // P <= P + M

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             trunc;
  logic [1:0]       drain_cnt;
  logic [7:0]       pend_tag;
  logic             accept;
  logic [CNT_W-1:0] acc_cnt;
  logic             vec_end;

  // dsp_rst is high for the cycle after a reset edge, keeping the slice clear before new data.
  assign in_ready  = ((state == IDLE) || (state == ACCUM)) && !dsp_rst;
  assign accept    = in_valid && in_ready;
  assign res_valid = (state == HOLD);
  assign dbg_state = state;

  always_comb begin
    acc_cnt = (state == IDLE) ? CNT_W'(1) : count + CNT_W'(1);
    vec_end = in_last || (acc_cnt == CNT_W'(MAX_LEN));
  end

  // pend_tag is the tag for the operands registered this edge; the slice registers OPMODE
  // one stage later than A/B, so the tag is presented on dsp_opmode one cycle after them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      count      <= '0;
      trunc      <= 1'b0;
      drain_cnt  <= 2'd0;
      pend_tag   <= OP_CLEAR;
      dsp_a      <= 18'd0;
      dsp_b      <= 18'd0;
      dsp_opmode <= OP_CLEAR;
      dsp_ce     <= 1'b0;
      dsp_rst    <= 1'b1;
      res_data   <= 48'd0;
      res_count  <= '0;
      res_trunc  <= 1'b0;
    end else begin
      dsp_ce     <= 1'b1;
      dsp_rst    <= 1'b0;
      dsp_opmode <= pend_tag;
      dsp_a      <= accept ? in_a : 18'd0;
      dsp_b      <= accept ? in_b : 18'd0;
      case (state)
        IDLE, ACCUM: begin
          pend_tag <= (state == IDLE) ? (accept ? OP_MUL : OP_CLEAR) : OP_MAC;
          if (accept) begin
            count <= acc_cnt;
            if (vec_end) begin
              state     <= DRAIN;
              trunc     <= !in_last;
              drain_cnt <= 2'd0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DRAIN: begin
          // Last operands reach P three edges after acceptance; capture on the fourth.
          pend_tag  <= OP_MAC;
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd3) begin
            res_data  <= dsp_p;
            res_count <= count;
            res_trunc <= trunc;
            state     <= HOLD;
          end
        end
        HOLD: begin
          pend_tag <= OP_MAC;
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// Bench for dsp48a1_mac_seq: behavioural DSP48A1 slice, vector table, corner sequences and
// randomized vectors scored against a plain-arithmetic dot-product model.
module tb_dsp48a1_mac_seq;

  localparam int ML    = 4;
  localparam int CNT_W = $clog2(ML + 1);
  localparam int R_W   = 48 + CNT_W + 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      in_a = 18'd0;
  logic [17:0]      in_b = 18'd0;
  logic             in_last = 1'b0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [47:0]      res_data;
  logic [CNT_W-1:0] res_count;
  logic             res_trunc;
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic             dsp_rst;
  logic [47:0]      dsp_p;
  logic [1:0]       dbg_state;

  dsp48a1_mac_seq #(.MAX_LEN(ML)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_last(in_last), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count), .res_trunc(res_trunc), .dsp_a(dsp_a),
    .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
    .dsp_p(dsp_p), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DSP48A1 slice (A1/B1, M, OPMODE, P registers) ----------------
  logic signed [17:0] a1_r = '0, b1_r = '0;
  logic signed [35:0] m_r = '0;
  logic [7:0]         op_r = '0;
  logic [47:0]        p_r = '0;
  always @(posedge clk) begin
    if (dsp_rst) begin
      a1_r <= '0; b1_r <= '0; m_r <= '0; op_r <= '0; p_r <= '0;
    end else if (dsp_ce) begin
      a1_r <= signed'(dsp_a);
      b1_r <= signed'(dsp_b);
      m_r  <= a1_r * b1_r;
      op_r <= dsp_opmode;
      p_r  <= ((op_r[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0) +
              ((op_r[3:2] == 2'b10) ? p_r : 48'd0);
    end
  end
  assign dsp_p = p_r;

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [R_W-1:0] exp_q[$];
  int             exp_t_q[$];
  logic [R_W-1:0] got_q[$];
  logic [47:0]    m_acc = '0;
  int             m_cnt = 0;
  bit             rnd_ready = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Reference: dot product modulo 2^48, closed by IN_LAST or by the MAX_LEN-th pair.
  task automatic model_accept(input logic [17:0] a, input logic [17:0] b, input logic last);
    longint p;
    p = longint'(signed'(a)) * longint'(signed'(b));
    m_acc = m_acc + p[47:0];
    m_cnt++;
    if (last || m_cnt == ML) begin
      exp_q.push_back({m_acc, CNT_W'(m_cnt), !last});
      exp_t_q.push_back(cyc + 4);
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  // Monitor: one record per result, stability while held, drop after the handshake.
  initial begin
    logic [R_W-1:0] e, h;
    bit held, drop_due;
    int t;
    held = 0; drop_due = 0; h = '0;
    forever begin
      @(negedge clk);
      if (drop_due) begin
        chk("res_valid_drop", res_valid, 0);
        drop_due = 0;
        held = 0;
      end else if (res_valid && !held) begin
        held = 1;
        h = {res_data, res_count, res_trunc};
        got_q.push_back(h);
        chk("result_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          t = exp_t_q.pop_front();
          chk("res_data", res_data, e[R_W-1 -: 48]);
          chk("res_count", res_count, e[CNT_W:1]);
          chk("res_trunc", res_trunc, e[0]);
          chk("res_latency", cyc, t);
        end
      end else if (res_valid) begin
        chk("res_stable", {res_data, res_count, res_trunc}, h);
        chk("in_ready_in_hold", in_ready, 0);
      end
      if (res_valid && res_ready) drop_due = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_ready) res_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, input logic last);
    int budget = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready && budget < 200) begin step(); budget++; end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    step();
    model_accept(a, b, last);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_result(output logic [R_W-1:0] r);
    int b = 0;
    while (got_q.size() == 0 && b < 300) begin step(); b++; end
    chk("result_timeout", got_q.size() > 0, 1);
    r = (got_q.size() > 0) ? got_q.pop_front() : '0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    int          gap;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    logic [47:0] exp_data;
    int          exp_cnt;
    logic        exp_trunc;
  } vec_t;

  function automatic vec_t mk(input int n, input int gap, input int a0, input int b0,
                              input int a1, input int b1, input int a2, input int b2,
                              input int a3, input int b3, input logic [47:0] d, input int c);
    vec_t v;
    v.n = n; v.gap = gap;
    v.a[0] = 18'(a0); v.a[1] = 18'(a1); v.a[2] = 18'(a2); v.a[3] = 18'(a3);
    v.b[0] = 18'(b0); v.b[1] = 18'(b1); v.b[2] = 18'(b2); v.b[3] = 18'(b3);
    v.exp_data = d; v.exp_cnt = c; v.exp_trunc = 1'b0;
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    vec_t vt[5];
    logic [R_W-1:0] r;
    int bud;
    vt[0] = mk(3, 0, 3, 4, 5, 6, -2, 7, 0, 0, 48'h1C, 3);
    vt[1] = mk(3, 2, 3, 4, 5, 6, -2, 7, 0, 0, 48'h1C, 3);
    vt[2] = mk(1, 0, -131072, -131072, 0, 0, 0, 0, 0, 0, 48'h000400000000, 1);
    vt[3] = mk(2, 1, 2, 3, -1, 4, 0, 0, 0, 0, 48'd2, 2);
    vt[4] = mk(4, 0, 100, -200, 7, 7, 0, 5, -3, -3, 48'hFFFFFFFFB21A, 4);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_trunc", res_trunc, 0);
    chk("rst_dsp_ab", {dsp_a, dsp_b}, 0);
    chk("rst_dsp_opmode", dsp_opmode, 0);
    chk("rst_dsp_ce", dsp_ce, 0);
    chk("rst_dsp_rst", dsp_rst, 1);
    chk("rst_dbg_state", dbg_state, 0);
    rstn = 1'b1;
    step();
    chk("post_rst_dsp_rst", dsp_rst, 0);
    chk("post_rst_dsp_ce", dsp_ce, 1);
    chk("post_rst_in_ready", in_ready, 1);

    // table-driven vectors
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      for (int i = 0; i < vt[v].n; i++) begin
        send_pair(vt[v].a[i], vt[v].b[i], i == vt[v].n - 1);
        if (i < vt[v].n - 1) idle(vt[v].gap);
      end
      wait_result(r);
      chk($sformatf("tbl%0d_data", v), r[R_W-1 -: 48], vt[v].exp_data);
      chk($sformatf("tbl%0d_count", v), r[CNT_W:1], vt[v].exp_cnt);
      chk($sformatf("tbl%0d_trunc", v), r[0], vt[v].exp_trunc);
    end

    // operand/OPMODE alignment across bubbles
    idle(3);
    got_q.delete();
    chk("idle_opmode", dsp_opmode, 8'h00);
    send_pair(18'd3, 18'd4, 1'b0);
    chk("seq_dsp_a", dsp_a, 3);
    chk("seq_dsp_b", dsp_b, 4);
    step();
    chk("seq_opmode_first", dsp_opmode, 8'h01);
    chk("seq_bubble_ab", {dsp_a, dsp_b}, 0);
    step();
    chk("seq_opmode_bubble", dsp_opmode, 8'h09);
    chk("seq_bubble_ab2", {dsp_a, dsp_b}, 0);
    send_pair(18'd5, 18'd6, 1'b0);
    idle(2);
    send_pair(-18'sd2, 18'd7, 1'b1);
    wait_result(r);
    chk("seq_data", r[R_W-1 -: 48], 48'h1C);

    // forced cut at MAX_LEN, remaining pairs form the next vector
    got_q.delete();
    for (int i = 0; i < 6; i++) send_pair(18'd1, 18'd1, i == 5);
    wait_result(r);
    chk("cut1_data", r[R_W-1 -: 48], 4);
    chk("cut1_count", r[CNT_W:1], 4);
    chk("cut1_trunc", r[0], 1);
    wait_result(r);
    chk("cut2_data", r[R_W-1 -: 48], 2);
    chk("cut2_count", r[CNT_W:1], 2);
    chk("cut2_trunc", r[0], 0);

    // result held while consumer stalls
    got_q.delete();
    res_ready = 1'b0;
    send_pair(18'd2, 18'd5, 1'b1);
    bud = 0;
    while (!res_valid && bud < 50) begin step(); bud++; end
    chk("stall_res_valid_rise", res_valid, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res_data", res_data, 10);
      chk("stall_in_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    step();
    chk("release_res_valid", res_valid, 0);
    chk("release_in_ready", in_ready, 1);

    // reset in the middle of a vector
    got_q.delete();
    send_pair(18'd1, 18'd2, 1'b0);
    send_pair(18'd3, 18'd4, 1'b0);
    rstn = 1'b0;
    step();
    m_acc = '0;
    m_cnt = 0;
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    chk("mid_rst_res_count", res_count, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_dsp", {dsp_a, dsp_b, dsp_opmode}, 0);
    chk("mid_rst_dsp_ce", dsp_ce, 0);
    chk("mid_rst_dsp_rst", dsp_rst, 1);
    rstn = 1'b1;
    step();
    chk("mid_rst_dsp_rst_drop", dsp_rst, 0);
    chk("mid_rst_ready_back", in_ready, 1);
    idle(8);
    chk("mid_rst_no_result", got_q.size(), 0);
    send_pair(18'd2, 18'd3, 1'b1);
    wait_result(r);
    chk("after_rst_data", r[R_W-1 -: 48], 6);
    chk("after_rst_count", r[CNT_W:1], 1);

    // randomized vectors against the model
    rnd_ready = 1;
    for (int v = 0; v < 40; v++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        logic [17:0] a, b;
        a = ($urandom_range(0, 7) == 0) ? 18'h20000 : 18'($urandom);
        b = ($urandom_range(0, 7) == 0) ? 18'h1FFFF : 18'($urandom);
        send_pair(a, b, i == n - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    bud = 0;
    while (exp_q.size() > 0 && bud < 500) begin step(); bud++; end
    chk("exp_q_drained", exp_q.size(), 0);
    rnd_ready = 0;
    res_ready = 1'b1;
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
